// File: rtl/stream_pkg.sv
// Shared types for the stream merge path: element layout, merge FSM states, EOS marker.
package stream_pkg;

   localparam int  ELEM_W   = 64;
   localparam logic EOS_FLAG = 1'b1;

   typedef struct packed {
      logic [ELEM_W-1:0] field0;
      logic              field1;
   } stream_elem_t;

   typedef enum logic [1:0] {
      RUN,
      EOS_OUT,
      CTRL,
      DONE
   } merge_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr_i, modulo N.
module rr_arbiter #(
   parameter int N  = 2,
   parameter int IW = 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  grant_o,
   output logic [IW-1:0] idx_o
);

   logic found;
   int   j;

   // Walk the requesters starting at the pointer; the first hit wins.
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      j       = 0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr_i) + k;
         if (j >= N) j = j - N;
         if (!found && req_i[j]) begin
            found      = 1'b1;
            grant_o[j] = 1'b1;
            idx_o      = IW'(j);
         end
      end
   end

endmodule

// File: rtl/stream_merge_arbiter.sv
// Round-robin merge of N element streams into one registered output; emits one
// merged EOS after every input has ended, then a completion token on outCtrl.
module stream_merge_arbiter
   import stream_pkg::*;
#(
   parameter int N = 2,
   parameter int W = 64
) (
   input  logic           clock,
   input  logic           reset,
   input  logic [N-1:0]   in_valid,
   output logic [N-1:0]   in_ready,
   input  logic [N*W-1:0] in_data_field0,
   input  logic [N-1:0]   in_data_field1,
   output logic           out0_valid,
   input  logic           out0_ready,
   output logic [W-1:0]   out0_data_field0,
   output logic           out0_data_field1,
   output logic           outCtrl_valid,
   input  logic           outCtrl_ready
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   merge_state_e  state_q, state_d;
   logic [N-1:0]  done_q, done_d;
   logic [IW-1:0] rr_q, rr_d;
   logic          out_vld_q, out_vld_d;
   logic [W-1:0]  out_data_q, out_data_d;
   logic          out_eos_q, out_eos_d;
   logic          ctrl_vld_q, ctrl_vld_d;

   logic [N-1:0]  eligible, grant;
   logic [IW-1:0] gidx;
   logic          can_load, take, drain, sel_eos;
   logic [W-1:0]  sel_data;

   // Inputs that already delivered EOS drop out of arbitration for good.
   assign eligible = in_valid & ~done_q;

   rr_arbiter #(.N(N), .IW(IW)) u_arb (
      .req_i   (eligible),
      .ptr_i   (rr_q),
      .grant_o (grant),
      .idx_o   (gidx)
   );

   // Output slot is free if empty or draining this edge, so loads run back-to-back.
   assign can_load = !out_vld_q || out0_ready;
   assign in_ready = (state_q == RUN && can_load) ? grant : '0;
   assign take     = |in_ready;
   assign drain    = out_vld_q && out0_ready;
   assign sel_data = in_data_field0[gidx*W +: W];
   assign sel_eos  = in_data_field1[gidx];

   assign out0_valid       = out_vld_q;
   assign out0_data_field0 = out_data_q;
   assign out0_data_field1 = out_eos_q;
   assign outCtrl_valid    = ctrl_vld_q;

   // Next-state: arbitration, EOS bookkeeping and the end-of-run sequence.
   always_comb begin
      state_d    = state_q;
      done_d     = done_q;
      rr_d       = rr_q;
      out_vld_d  = out_vld_q && !out0_ready;
      out_data_d = out_data_q;
      out_eos_d  = out_eos_q;
      ctrl_vld_d = ctrl_vld_q;
      case (state_q)
         RUN: begin
            if (take) begin
               rr_d = (gidx == IW'(N-1)) ? '0 : gidx + 1'b1;
               if (sel_eos) begin
                  // Input EOS is swallowed; only the merged EOS reaches out0.
                  done_d[gidx] = 1'b1;
               end else begin
                  out_vld_d  = 1'b1;
                  out_data_d = sel_data;
                  out_eos_d  = 1'b0;
               end
            end else if (&done_q && can_load) begin
               out_vld_d  = 1'b1;
               out_data_d = '0;
               out_eos_d  = EOS_FLAG;
               state_d    = EOS_OUT;
            end
         end
         EOS_OUT: begin
            if (drain) begin
               ctrl_vld_d = 1'b1;
               state_d    = CTRL;
            end
         end
         CTRL: begin
            if (ctrl_vld_q && outCtrl_ready) begin
               ctrl_vld_d = 1'b0;
               state_d    = DONE;
            end
         end
         DONE: ;
         default: state_d = RUN;
      endcase
   end

   // State registers with synchronous reset; an in-flight element is dropped.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= RUN;
         done_q     <= '0;
         rr_q       <= '0;
         out_vld_q  <= 1'b0;
         out_data_q <= '0;
         out_eos_q  <= 1'b0;
         ctrl_vld_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         done_q     <= done_d;
         rr_q       <= rr_d;
         out_vld_q  <= out_vld_d;
         out_data_q <= out_data_d;
         out_eos_q  <= out_eos_d;
         ctrl_vld_q <= ctrl_vld_d;
      end
   end

endmodule

// File: tb/tb_stream_merge_arbiter.sv
// Randomized scoreboard bench for stream_merge_arbiter (N=2, W=64).
module tb_stream_merge_arbiter;
   import stream_pkg::*;

   localparam int N = 2;
   localparam int W = 64;

   logic           clock = 1'b0;
   logic           reset = 1'b1;
   logic [N-1:0]   in_valid = '0;
   logic [N-1:0]   in_ready;
   logic [N*W-1:0] in_data_field0 = '0;
   logic [N-1:0]   in_data_field1 = '0;
   logic           out0_valid;
   logic           out0_ready = 1'b0;
   logic [W-1:0]   out0_data_field0;
   logic           out0_data_field1;
   logic           outCtrl_valid;
   logic           outCtrl_ready = 1'b0;

   stream_merge_arbiter #(.N(N), .W(W)) dut (
      .clock            (clock),
      .reset            (reset),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_data_field0   (in_data_field0),
      .in_data_field1   (in_data_field1),
      .out0_valid       (out0_valid),
      .out0_ready       (out0_ready),
      .out0_data_field0 (out0_data_field0),
      .out0_data_field1 (out0_data_field1),
      .outCtrl_valid    (outCtrl_valid),
      .outCtrl_ready    (outCtrl_ready)
   );

   always #5 clock = ~clock;

   int vecs  = 0;
   int errs  = 0;
   int n_out = 0;

   stream_elem_t exp_q[$];
   stream_elem_t src_q[N][$];
   bit           vld_hold[N];
   int           start_dly[N];

   // Reference model: 0 running, 1 sending merged EOS, 2 control token, 3 finished.
   int m_state, m_rr;
   bit m_done[N];
   bit m_ov, m_ctrl;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
      end
   endtask

   task automatic push(input int i, input logic [63:0] d, input bit eos);
      stream_elem_t e;
      e.field0 = eos ? 64'd0 : d;
      e.field1 = eos;
      src_q[i].push_back(e);
   endtask

   task automatic model_clear();
      m_state = 0; m_rr = 0; m_ov = 0; m_ctrl = 0;
      exp_q.delete();
      for (int i = 0; i < N; i++) begin
         m_done[i] = 0; vld_hold[i] = 0; start_dly[i] = 0;
         src_q[i].delete();
      end
   endtask

   task automatic do_reset(input bit chk_data);
      @(negedge clock);
      reset = 1'b1; in_valid = '0; out0_ready = 1'b0; outCtrl_ready = 1'b0;
      @(negedge clock);
      @(negedge clock);
      #1;
      chk("rst_out_valid", out0_valid, 0);
      chk("rst_ctrl_valid", outCtrl_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      if (chk_data) begin
         chk("rst_out_data", out0_data_field0, 0);
         chk("rst_out_eos", out0_data_field1, 0);
      end
      model_clear();
      reset = 1'b0;
   endtask

   // Monitor: every output handshake pops the next expected element.
   always @(negedge clock) begin
      stream_elem_t e;
      #2;
      if (!reset && out0_valid && out0_ready) begin
         n_out++;
         if (exp_q.size() == 0) begin
            vecs++; errs++;
            $display("FAIL sb_unexpected actual=%h expected=none @%0t", out0_data_field0, $time);
         end else begin
            e = exp_q.pop_front();
            chk("out_data", out0_data_field0, e.field0);
            chk("out_eos", {63'd0, out0_data_field1}, {63'd0, e.field1});
         end
      end
   end

   // One run: drive sources cycle by cycle, step the model, check handshake signals.
   task automatic run(input int ncyc, input int p_ordy, input int p_gap, input int ctrl_wait,
                      input int bp_start, input int bp_len, input int stop_outs, input bit want_done);
      int ctrl_cyc, g, j;
      bit can_load, n_ov;
      logic [N-1:0] exp_rdy;
      stream_elem_t tok;
      ctrl_cyc = 0;
      n_out = 0;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clock);
         if (stop_outs > 0 && n_out >= stop_outs) break;
         for (int i = 0; i < N; i++) begin
            if (m_state == 3) begin
               in_valid[i] = 1'($urandom);
               in_data_field0[i*W +: W] = {$urandom, $urandom};
               in_data_field1[i] = 1'($urandom);
            end else begin
               if (!vld_hold[i] && src_q[i].size() > 0 && c >= start_dly[i])
                  vld_hold[i] = ($urandom_range(99) >= p_gap);
               in_valid[i] = vld_hold[i];
               if (vld_hold[i]) begin
                  in_data_field0[i*W +: W] = src_q[i][0].field0;
                  in_data_field1[i] = src_q[i][0].field1;
               end else begin
                  in_data_field0[i*W +: W] = {$urandom, $urandom};
                  in_data_field1[i] = 1'($urandom);
               end
            end
         end
         if (c >= bp_start && c < bp_start + bp_len) out0_ready = 1'b0;
         else out0_ready = ($urandom_range(99) < p_ordy);
         if (ctrl_wait >= 0) outCtrl_ready = (m_state == 2 && ctrl_cyc >= ctrl_wait);
         else outCtrl_ready = 1'($urandom);
         if (m_state == 2) ctrl_cyc++;
         #1;
         can_load = !m_ov || out0_ready;
         g = -1;
         for (int k = 0; k < N; k++) begin
            j = (m_rr + k) % N;
            if (g < 0 && in_valid[j] && !m_done[j]) g = j;
         end
         exp_rdy = (m_state == 0 && can_load && g >= 0) ? (N'(1) << g) : '0;
         chk("in_ready", {62'd0, in_ready}, {62'd0, exp_rdy});
         chk("out_valid", {63'd0, out0_valid}, {63'd0, m_ov});
         chk("ctrl_valid", {63'd0, outCtrl_valid}, {63'd0, m_ctrl});
         n_ov = m_ov && !out0_ready;
         if (m_state == 0) begin
            if (exp_rdy != 0) begin
               tok = src_q[g].pop_front();
               vld_hold[g] = 0;
               m_rr = (g + 1) % N;
               if (tok.field1) m_done[g] = 1;
               else begin n_ov = 1; exp_q.push_back(tok); end
            end else if (m_done[0] && m_done[1] && can_load) begin
               n_ov = 1;
               tok.field0 = 64'd0; tok.field1 = 1'b1;
               exp_q.push_back(tok);
               m_state = 1;
            end
         end else if (m_state == 1) begin
            if (m_ov && out0_ready) begin m_ctrl = 1; m_state = 2; end
         end else if (m_state == 2) begin
            if (outCtrl_ready) begin m_ctrl = 0; m_state = 3; end
         end
         m_ov = n_ov;
      end
      if (want_done) begin
         chk("run_done_state", 64'(m_state), 64'd3);
         chk("sb_drained", 64'(exp_q.size()), 64'd0);
      end
   endtask

   initial begin : wdog
      #2000000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      model_clear();
      do_reset(1'b1);

      // Alternating inputs, full output throughput.
      push(0, 1, 0); push(0, 2, 0); push(0, 3, 0); push(0, 0, 1);
      push(1, 10, 0); push(1, 20, 0); push(1, 30, 0); push(1, 0, 1);
      run(40, 100, 0, 1, 0, 0, 0, 1);
      do_reset(1'b0);

      // Early end on input 0.
      push(0, 0, 1);
      push(1, 5, 0); push(1, 6, 0); push(1, 7, 0); push(1, 0, 1);
      run(40, 100, 0, 0, 0, 0, 0, 1);
      do_reset(1'b0);

      // Backpressure while the register holds 42.
      push(0, 42, 0); push(0, 43, 0); push(0, 0, 1);
      push(1, 0, 1); start_dly[1] = 8;
      run(40, 100, 0, 0, 1, 5, 0, 1);
      do_reset(1'b0);

      // Throughput: in0 streams 100..107 with in1 ending only afterwards.
      for (int v = 100; v < 108; v++) push(0, 64'(v), 0);
      push(0, 0, 1);
      push(1, 0, 1); start_dly[1] = 12;
      run(50, 100, 0, 0, 0, 0, 0, 1);
      do_reset(1'b0);

      // Reset mid-run after three outputs, then a short restart.
      for (int v = 0; v < 8; v++) begin
         push(0, {$urandom, $urandom}, 0);
         push(1, {$urandom, $urandom}, 0);
      end
      run(60, 100, 0, 0, 0, 0, 3, 0);
      do_reset(1'b0);
      push(0, 7, 0); push(0, 0, 1);
      push(1, 0, 1);
      run(30, 100, 0, 0, 0, 0, 0, 1);
      do_reset(1'b0);

      // Late outCtrl_ready; DONE then sees random in_valid.
      push(0, 0, 1);
      push(1, 9, 0); push(1, 0, 1);
      run(40, 100, 0, 4, 0, 0, 0, 1);
      do_reset(1'b0);

      // Randomized runs.
      for (int r = 0; r < 12; r++) begin
         for (int i = 0; i < N; i++) begin
            int len;
            len = $urandom_range(6);
            for (int v = 0; v < len; v++) push(i, {$urandom, $urandom}, 0);
            push(i, 0, 1);
            start_dly[i] = $urandom_range(3);
         end
         run(200, $urandom_range(30, 100), $urandom_range(60), -1, 0, 0, 0, 1);
         do_reset(1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
